// File: rtl/sub_pipe_pkg.sv
// ============================================================================
//  Module   : sub_pipe_pkg
//  Purpose  : Shared definitions for the pipelined subtractor: default
//             operand width, the result flag bundle and saturation constants.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sub_pipe_pkg;

    // Default operand/result width of the PE datapath.
    localparam int WIDTH_DEF = 16;

    // Saturation limits at the default width. The top regenerates them for
    // any other WIDTH.
    localparam logic [WIDTH_DEF-1:0] MAX_POS = 16'h7FFF;
    localparam logic [WIDTH_DEF-1:0] MAX_NEG = 16'h8000;

    // Flag bundle in O1..O5 order.
    typedef struct packed {
        logic c_out;  // carry-out, 1 = no borrow
        logic z;      // result is zero
        logic n;      // result MSB
        logic c;      // same as c_out
        logic v;      // signed overflow
    } flags_t;

endpackage

`default_nettype wire

// File: rtl/sub_pipe_stage.sv
// ============================================================================
//  Module   : sub_pipe_stage
//  Purpose  : Generic one-entry valid/ready pipeline register. Holds one beat
//             of data; accepts a new beat when empty or when the held beat
//             leaves in the same cycle. en=0 freezes everything.
//  Ports    : clk, rst (sync, active-high), en
//             up_valid/up_ready/up_data   - upstream side
//             dn_valid/dn_ready/dn_data   - downstream side
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          w_advance;
    logic          w_load;

    assign w_advance = en & r_valid & dn_ready;
    assign up_ready  = en & (~r_valid | w_advance);
    assign w_load    = up_valid & up_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
        end else if (w_advance) begin
            r_valid <= 1'b0;
        end
    end

    // Data only moves with a real beat, so bubbles never toggle it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (w_load) begin
            r_data <= up_data;
        end
    end

    assign dn_valid = r_valid;
    assign dn_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/sub_pipe.sv
// ============================================================================
//  Module   : sub_pipe
//  Purpose  : Two-stage pipelined subtractor computing a + ~b + cin with the
//             adder-compatible flag bundle. Stage 1 resolves the low SPLIT
//             bits, stage 2 the high segment; flags are formed from the
//             stage-2 register.
//  Ports    : CLK, ASYNCRESET (sync, active-high), clk_en
//             in_valid/in_ready, a, b, cin      - operand beat
//             out_valid/out_ready, O0..O5        - result beat
//             O0 result, O1 carry-out, O2 zero, O3 negative, O4 carry,
//             O5 signed overflow
//  Options  : SUB_SATURATE_EN - clamp O0 to the signed limit on overflow.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_pipe
    import sub_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SPLIT = 8
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             clk_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] O0,
    output logic             O1,
    output logic             O2,
    output logic             O3,
    output logic             O4,
    output logic             O5
);

    localparam int HI  = WIDTH - SPLIT;
    localparam int S1W = 2*HI + SPLIT + 1;   // a_hi, ~b_hi, low carry+sum
    localparam int S2W = WIDTH + 3;          // a_msb, b_msb, full sum

    // ---------------- stage 1: low segment ----------------
    logic [SPLIT:0]   w_lo_sum;
    logic [S1W-1:0]   w_s1_in;
    logic [S1W-1:0]   w_s1_q;
    logic             w_s1_valid;
    logic             w_s1_ready;
    logic             w_s2_ready;

    assign w_lo_sum = {1'b0, a[SPLIT-1:0]} + {1'b0, ~b[SPLIT-1:0]}
                    + {{SPLIT{1'b0}}, cin};
    assign w_s1_in  = {a[WIDTH-1:SPLIT], ~b[WIDTH-1:SPLIT], w_lo_sum};

    sub_pipe_stage #(.DW(S1W)) u_s1 (
        .clk      (CLK),
        .rst      (ASYNCRESET),
        .en       (clk_en),
        .up_valid (in_valid),
        .up_ready (w_s1_ready),
        .up_data  (w_s1_in),
        .dn_valid (w_s1_valid),
        .dn_ready (w_s2_ready),
        .dn_data  (w_s1_q)
    );

    // Reset forces in_ready low even while the valid bits are still set.
    assign in_ready = w_s1_ready & ~ASYNCRESET;

    // ---------------- stage 2: high segment ----------------
    logic [HI-1:0]  w_a_hi;
    logic [HI-1:0]  w_nb_hi;
    logic [HI:0]    w_hi_sum;
    logic [S2W-1:0] w_s2_in;
    logic [S2W-1:0] w_s2_q;
    logic           w_s2_valid;

    assign w_a_hi   = w_s1_q[S1W-1 -: HI];
    assign w_nb_hi  = w_s1_q[S1W-HI-1 -: HI];
    assign w_hi_sum = {1'b0, w_a_hi} + {1'b0, w_nb_hi} + {{HI{1'b0}}, w_s1_q[SPLIT]};
    assign w_s2_in  = {w_a_hi[HI-1], ~w_nb_hi[HI-1], w_hi_sum, w_s1_q[SPLIT-1:0]};

    sub_pipe_stage #(.DW(S2W)) u_s2 (
        .clk      (CLK),
        .rst      (ASYNCRESET),
        .en       (clk_en),
        .up_valid (w_s1_valid),
        .up_ready (w_s2_ready),
        .up_data  (w_s2_in),
        .dn_valid (w_s2_valid),
        .dn_ready (out_ready),
        .dn_data  (w_s2_q)
    );

    // ---------------- flags ----------------
    logic             w_a_msb;
    logic             w_b_msb;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    flags_t           w_flags;

    assign w_a_msb = w_s2_q[WIDTH+2];
    assign w_b_msb = w_s2_q[WIDTH+1];
    assign w_raw   = w_s2_q[WIDTH-1:0];
    assign w_ovf   = (w_a_msb ^ w_b_msb) & (w_raw[WIDTH-1] ^ w_a_msb);

`ifdef SUB_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    // Clamp toward the sign of the minuend.
    assign w_res = w_ovf ? (w_a_msb ? SAT_NEG : SAT_POS) : w_raw;
`else
    assign w_res = w_raw;
`endif

    assign w_flags.c_out = w_s2_q[WIDTH];
    assign w_flags.z     = (w_res == '0);
    assign w_flags.n     = w_res[WIDTH-1];
    assign w_flags.c     = w_s2_q[WIDTH];
    assign w_flags.v     = w_ovf;

    // Outputs read as zero whenever no beat is presented (incl. after reset).
    assign out_valid = w_s2_valid;
    assign O0 = w_s2_valid ? w_res : '0;
    assign {O1, O2, O3, O4, O5} = w_s2_valid ? w_flags : '0;

endmodule

`default_nettype wire

// File: tb/tb_sub_pipe.sv
// ============================================================================
//  Module   : tb_sub_pipe
//  Purpose  : Scoreboard bench for sub_pipe: directed vectors, stall,
//             reset-flush and clock-enable freeze scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sub_pipe;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        n;
        logic        v;
    } vec_t;

    logic        CLK = 1'b0;
    logic        ASYNCRESET;
    logic        clk_en;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] O0;
    logic        O1, O2, O3, O4, O5;

    int   total = 0;
    int   bad   = 0;
    int   n_emit = 0;
    vec_t vt[9];
    vec_t exp_q[$];

    always #5 CLK = ~CLK;

    sub_pipe dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .clk_en     (clk_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .O0         (O0),
        .O1         (O1),
        .O2         (O2),
        .O3         (O3),
        .O4         (O4),
        .O5         (O5)
    );

    function automatic logic [20:0] bundle_of(input vec_t v);
        return {v.res, v.c, v.z, v.n, v.c, v.v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: a handshake happens on the next rising edge whenever these
    // conditions hold mid-cycle.
    always @(negedge CLK) begin
        if (!ASYNCRESET && clk_en && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got O0=%h expected no beat", O0);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                if ({O0, O1, O2, O3, O4, O5} !== bundle_of(e)) begin
                    bad++;
                    $display("FAIL result a=%h b=%h: got %h expected %h",
                             e.a, e.b, {O0, O1, O2, O3, O4, O5}, bundle_of(e));
                end
            end
            n_emit++;
        end
    end

    task automatic send(input vec_t v);
        bit got = 1'b0;
        in_valid = 1'b1; a = v.a; b = v.b; cin = v.cin;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge CLK);
            if (in_ready) begin
                exp_q.push_back(v);
                got = 1'b1;
            end
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        check("send_accept", {31'd0, got}, 32'd1);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(posedge CLK); #1;
            k++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int idx;
        int cyc;
        int base;

        vt[0] = '{16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[1] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[2] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef SUB_SATURATE_EN
        vt[3] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[4] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        vt[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[4] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
        vt[5] = '{16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[6] = '{16'h0100, 16'h0001, 1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[7] = '{16'h00FF, 16'h00FF, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[8] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};

        ASYNCRESET = 1'b1; clk_en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_outputs", {11'd0, O0, O1, O2, O3, O4, O5}, 32'd0);
        @(posedge CLK); #1;
        ASYNCRESET = 1'b0;
        @(negedge CLK);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge CLK); #1;

        // Directed vectors, back to back
        for (int i = 0; i < 9; i++) send(vt[i]);
        drain();

        // Stall: 4 cycles of out_ready=0 with a continuous stream
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1; a = vt[0].a; b = vt[0].b; cin = vt[0].cin;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (in_ready) begin exp_q.push_back(vt[idx]); idx++; end
            @(posedge CLK); #1;
            a = vt[idx].a; b = vt[idx].b; cin = vt[idx].cin;
        end
        check("stall_accepted", idx, 32'd2);
        @(negedge CLK);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge CLK); #1;
        out_ready = 1'b1;
        base = n_emit;
        cyc = 0;
        while (n_emit < base + 6 && cyc < 40) begin
            @(negedge CLK);
            if (in_valid && in_ready) begin exp_q.push_back(vt[idx]); idx++; end
            #1;
            cyc++;
            @(posedge CLK); #1;
            if (idx < 6) begin a = vt[idx].a; b = vt[idx].b; cin = vt[idx].cin; end
            else in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("stream_cycles", cyc, 32'd6);
        check("stream_count", n_emit - base, 32'd6);
        drain();

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(vt[1]);
        send(vt[2]);
        ASYNCRESET = 1'b1; out_ready = 1'b1;
        @(negedge CLK);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        exp_q.delete();
        @(posedge CLK); #1;
        ASYNCRESET = 1'b0;
        @(negedge CLK);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready_after", {31'd0, in_ready}, 32'd1);
        repeat (5) @(posedge CLK);
        #1;

        // Clock-enable freeze with a beat presented
        out_ready = 1'b0;
        send(vt[0]);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check("freeze_out_valid_rise", {31'd0, out_valid}, 32'd1);
        clk_en = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("freeze_out_valid", {31'd0, out_valid}, 32'd1);
            check("freeze_outputs", {11'd0, O0, O1, O2, O3, O4, O5}, {11'd0, bundle_of(vt[0])});
            check("freeze_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge CLK); #1;
        end
        check("freeze_pending", exp_q.size(), 32'd1);
        clk_en = 1'b1;
        drain();
        repeat (2) @(posedge CLK);
        #1;
        check("final_out_valid", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
